// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg
//   Shared definitions for the ALU-sharing arbiter slice: the rv32i ALU opcode
//   encoding (alu_instr_e) and the default datapath width.
//   No ports (package).
package alu_share_arb_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SRA  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_NOP  = 4'b1111
  } alu_instr_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if
//   Request and response handshake bundle between the requesters / response
//   consumer (master) and the ALU-sharing arbiter (slave).
//   Request side : req_valid, req_ready, req_op1, req_op2, req_instr
//                  (operand/opcode buses carry slice i for requester i)
//   Response side: rsp_valid, rsp_ready, rsp_id, rsp_result
interface alu_share_arb_if
  import alu_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_op1;
  logic [NUM_REQ*XLEN-1:0] req_op2;
  logic [NUM_REQ*4-1:0]    req_instr;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [XLEN-1:0]         rsp_result;

  modport master (
    output req_valid, req_op1, req_op2, req_instr, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_instr, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/alu.sv
// alu
//   Combinational rv32i ALU shared by the arbiter. Unknown opcodes give 0.
//   op_1, op_2  in   XLEN  operands
//   alu_instr   in   4     opcode (alu_instr_e encoding)
//   result      out  XLEN  result
module alu
  import alu_share_arb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
)(
  input  logic [XLEN-1:0] op_1,
  input  logic [XLEN-1:0] op_2,
  input  logic [3:0]      alu_instr,
  output logic [XLEN-1:0] result
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = op_2[SHW-1:0];

  always_comb begin
    result = '0;
    case (alu_instr)
      ALU_AND:  result = op_1 & op_2;
      ALU_OR:   result = op_1 | op_2;
      ALU_ADD:  result = op_1 + op_2;
      ALU_SUB:  result = op_1 - op_2;
      ALU_XOR:  result = op_1 ^ op_2;
      ALU_SLL:  result = op_1 << shamt;
      ALU_SRL:  result = op_1 >> shamt;
      ALU_SRA:  result = XLEN'($signed(op_1) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_1) < $signed(op_2))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_1 < op_2)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb_pick.sv
// alu_arb_pick
//   Combinational picker: starting at index ptr and wrapping, selects the first
//   asserted bit of req.
//   req          in   NUM_REQ  request vector
//   ptr          in   IDW      search start index (tie to 0 for fixed priority)
//   grant_onehot out  NUM_REQ  one-hot winner (zero when no request)
//   grant_idx    out  IDW      winner index
//   grant_any    out  1        any request present
module alu_arb_pick
  import alu_share_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = $clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_any
);

  int cand;

  // Walk the requesters in order ptr, ptr+1, ... modulo NUM_REQ; first hit wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    cand         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && req[cand]) begin
        grant_any          = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Shares one combinational ALU between NUM_REQ requesters. Grants one request
//   per cycle when the response slot is free or draining, drives the ALU with the
//   winner's operands, and registers the result with the winner's index.
//   Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority
//   (lowest index wins).
//   clk          in   1     rising-edge clock
//   rst_n        in   1     synchronous active-low reset
//   bus          slave      request/response handshakes (alu_share_arb_if)
//   alu_op_1     out  XLEN  to ALU op_1
//   alu_op_2     out  XLEN  to ALU op_2
//   alu_instr    out  4     to ALU opcode
//   alu_result   in   XLEN  from ALU result
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF
)(
  input  logic            clk,
  input  logic            rst_n,
  alu_share_arb_if.slave  bus,
  output logic [XLEN-1:0] alu_op_1,
  output logic [XLEN-1:0] alu_op_2,
  output logic [3:0]      alu_instr,
  input  logic [XLEN-1:0] alu_result
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic [IDW-1:0]     rr_ptr;
  logic               can_accept;
  logic               grant;

  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [XLEN-1:0]    rsp_result_q;

  // A grant needs a free (or draining) response slot; nothing is accepted in reset.
  assign can_accept = !rsp_valid_q || bus.rsp_ready;
  assign grant      = rst_n && can_accept && pick_any;

  alu_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req          (bus.req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .grant_any    (pick_any)
  );

  assign bus.req_ready = grant ? pick_onehot : '0;

  // Operand mux; idle drive is NOP so the ALU output sits at 0.
  always_comb begin
    alu_op_1  = '0;
    alu_op_2  = '0;
    alu_instr = ALU_NOP;
    if (grant) begin
      alu_op_1  = bus.req_op1[int'(pick_idx)*XLEN +: XLEN];
      alu_op_2  = bus.req_op2[int'(pick_idx)*XLEN +: XLEN];
      alu_instr = bus.req_instr[int'(pick_idx)*4 +: 4];
    end
  end

`ifdef ALU_ARB_RR_EN
  // Next search starts just past the winner, wrapping at the last requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (pick_idx == IDW'(NUM_REQ-1)) ? '0 : pick_idx + IDW'(1);
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // Response slot: load on grant (even while draining), clear on drain otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else if (grant) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= pick_idx;
      rsp_result_q <= alu_result;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb
//   Directed bench for alu_share_arb (NUM_REQ=3) with the real alu attached.
//   Expectations follow ALU_ARB_RR_EN (round-robin when defined, fixed priority
//   otherwise).
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] alu_op_1;
  logic [XLEN-1:0] alu_op_2;
  logic [3:0]      alu_instr;
  logic [XLEN-1:0] alu_result;

  int vectors;
  int miscompares;

  logic [2:0]  seq_rdy [4];
  logic [1:0]  seq_id  [4];
  logic [31:0] seq_res [4];

  alu_share_arb_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

  alu_share_arb #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op_1   (alu_op_1),
    .alu_op_2   (alu_op_2),
    .alu_instr  (alu_instr),
    .alu_result (alu_result)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .op_1      (alu_op_1),
    .op_2      (alu_op_2),
    .alu_instr (alu_instr),
    .result    (alu_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    bus.req_op1[i*XLEN +: XLEN] = a;
    bus.req_op2[i*XLEN +: XLEN] = b;
    bus.req_instr[i*4 +: 4]     = op;
  endtask

  // Drive valid vector and response ready, then settle before comb checks.
  task automatic applyStimulus(input logic [2:0] valid, input logic rdy);
    bus.req_valid = valid;
    bus.rsp_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef ALU_ARB_RR_EN
    seq_rdy = '{3'b001, 3'b010, 3'b001, 3'b010};
    seq_id  = '{2'd0, 2'd1, 2'd0, 2'd1};
    seq_res = '{32'd7, 32'hFF, 32'd7, 32'hFF};
`else
    seq_rdy = '{3'b001, 3'b001, 3'b001, 3'b001};
    seq_id  = '{2'd0, 2'd0, 2'd0, 2'd0};
    seq_res = '{32'd7, 32'd7, 32'd7, 32'd7};
`endif
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_instr = '0;
    bus.rsp_ready = 1'b1;

    // Reset with two requests pending
    setReq(0, 32'd5, 32'd7, ALU_ADD);
    setReq(1, 32'd1, 32'd1, ALU_ADD);
    applyStimulus(3'b011, 1'b1);
    tick();
    tick();
    checkOutput("rst_req_ready", bus.req_ready, 3'b000);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("rst_rsp_result", bus.rsp_result, 32'd0);
    checkOutput("rst_rsp_id", bus.rsp_id, 2'd0);
    checkOutput("rst_alu_instr", alu_instr, 4'hF);
    rst_n = 1'b1;

    // Single ADD
    applyStimulus(3'b001, 1'b1);
    checkOutput("add_req_ready", bus.req_ready, 3'b001);
    checkOutput("add_alu_op1", alu_op_1, 32'd5);
    tick();
    applyStimulus(3'b000, 1'b1);
    checkOutput("add_rsp_valid", bus.rsp_valid, 1'b1);
    checkOutput("add_rsp_id", bus.rsp_id, 2'd0);
    checkOutput("add_rsp_result", bus.rsp_result, 32'd12);
    tick();
    checkOutput("add_drain", bus.rsp_valid, 1'b0);

    // Contention from a freshly reset pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    setReq(0, 32'd10, 32'd3, ALU_SUB);
    setReq(1, 32'hF0, 32'h0F, ALU_XOR);
    applyStimulus(3'b011, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("cont_ready%0d", k), bus.req_ready, seq_rdy[k]);
      tick();
      checkOutput($sformatf("cont_valid%0d", k), bus.rsp_valid, 1'b1);
      checkOutput($sformatf("cont_id%0d", k), bus.rsp_id, seq_id[k]);
      checkOutput($sformatf("cont_res%0d", k), bus.rsp_result, seq_res[k]);
    end

    // Backpressure with req1 SLT -1 < 1 pending
    setReq(1, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
    applyStimulus(3'b010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp_ready%0d", k), bus.req_ready, 3'b000);
      tick();
      checkOutput($sformatf("bp_valid%0d", k), bus.rsp_valid, 1'b1);
      checkOutput($sformatf("bp_id%0d", k), bus.rsp_id, seq_id[3]);
      checkOutput($sformatf("bp_res%0d", k), bus.rsp_result, seq_res[3]);
    end
    applyStimulus(3'b010, 1'b1);
    checkOutput("bp_release_ready", bus.req_ready, 3'b010);
    tick();
    applyStimulus(3'b000, 1'b1);
    checkOutput("bp_slt_id", bus.rsp_id, 2'd1);
    checkOutput("bp_slt_res", bus.rsp_result, 32'd1);
    tick();
    checkOutput("bp_drain", bus.rsp_valid, 1'b0);

    // Only req2: SRA, then req0/req2 tie after wrap
    setReq(2, 32'h8000_0000, 32'd4, ALU_SRA);
    applyStimulus(3'b100, 1'b1);
    checkOutput("sra_ready", bus.req_ready, 3'b100);
    tick();
    setReq(0, 32'hFF00_FF00, 32'h0F0F_0F0F, ALU_AND);
    applyStimulus(3'b101, 1'b1);
    checkOutput("sra_id", bus.rsp_id, 2'd2);
    checkOutput("sra_res", bus.rsp_result, 32'hF800_0000);
    checkOutput("wrap_ready", bus.req_ready, 3'b001);
    tick();
    checkOutput("wrap_id", bus.rsp_id, 2'd0);
    checkOutput("wrap_res", bus.rsp_result, 32'h0F00_0F00);

    // Unknown opcode passes through and yields 0
    setReq(1, 32'd5, 32'd5, 4'hA);
    applyStimulus(3'b010, 1'b1);
    checkOutput("unk_alu_instr", alu_instr, 4'hA);
    tick();
    applyStimulus(3'b000, 1'b1);
    checkOutput("unk_id", bus.rsp_id, 2'd1);
    checkOutput("unk_res", bus.rsp_result, 32'd0);
    checkOutput("idle_alu_instr", alu_instr, 4'hF);
    checkOutput("idle_alu_op1", alu_op_1, 32'd0);
    tick();

    // Reset while a response is held
    setReq(0, 32'd1, 32'd2, ALU_OR);
    setReq(1, 32'd9, 32'd4, ALU_SUB);
    applyStimulus(3'b001, 1'b0);
    checkOutput("mid_ready", bus.req_ready, 3'b001);
    tick();
    applyStimulus(3'b011, 1'b0);
    checkOutput("mid_held", bus.rsp_valid, 1'b1);
    checkOutput("mid_res", bus.rsp_result, 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", bus.req_ready, 3'b000);
    tick();
    checkOutput("mid_rst_valid", bus.rsp_valid, 1'b0);
    checkOutput("mid_rst_res", bus.rsp_result, 32'd0);
    rst_n = 1'b1;
    applyStimulus(3'b011, 1'b1);
    checkOutput("post_rst_ready", bus.req_ready, 3'b001);
    tick();
    applyStimulus(3'b000, 1'b1);
    checkOutput("post_rst_id", bus.rsp_id, 2'd0);
    checkOutput("post_rst_res", bus.rsp_result, 32'd3);
    tick();
    checkOutput("post_rst_drain", bus.rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
